// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: instruction-memory req/ack bus (req, addr from fetch unit; ack, rdata from memory)
interface ifu_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  modport master (output req, addr, input ack, rdata);
  modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC/fetch FSM (FETCH/EXEC/HALT); ports clk, rst_n, imem bus, instr/instr_valid/pc/pc4 out, npc_op/rs_data/stall in, halt/retired out; ALIGN_CHECK_EN halts on misaligned npc
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  ifu_fetch_if.master      imem,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [31:0]      pc,
  output logic [31:0]      pc4,
  input  logic [2:0]       npc_op,
  input  logic [31:0]      rs_data,
  input  logic             stall,
  output logic             halt,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  state_t      state;
  logic [31:0] npc;
  assign pc4 = pc + 32'd4;
  always_comb npc = npc_op == 3'd1 ? pc4 + {{14{instr[15]}}, instr[15:0], 2'b00} :
                    npc_op == 3'd2 ? {pc4[31:28], instr[25:0], 2'b00} :
                    npc_op == 3'd3 ? rs_data : pc4;
  assign imem.req    = rst_n && state == FETCH;
  assign imem.addr   = pc;
  assign instr_valid = state == EXEC;
`ifdef ALIGN_CHECK_EN
  assign halt = state == HALT;
`else
  assign halt = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      instr   <= '0;
      retired <= '0;
    end else begin
      case (state)
        FETCH: if (imem.ack) begin
          instr <= imem.rdata;
          state <= EXEC;
        end
        EXEC: if (!stall) begin
`ifdef ALIGN_CHECK_EN
          if (npc[1:0] != 2'b00) state <= HALT;
          else begin
            pc      <= npc;
            retired <= retired + CNT_W'(1);
            state   <= FETCH;
          end
`else
          pc      <= npc & ~32'd3;
          retired <= retired + CNT_W'(1);
          state   <= FETCH;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: randomized self-checking bench for ifu_fetch against a behavioural PC model
module tb_ifu_fetch;
  logic        clk = 0, rst_n = 0;
  logic [31:0] instr, pc, pc4, rs_data, retired;
  logic        instr_valid, stall, halt;
  logic [2:0]  npc_op;
  int          errs = 0, checks = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] m_pc;
  int unsigned m_ret;
  bit          m_halt;
  always #5 clk = ~clk;
  ifu_fetch_if imem();
  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem(imem), .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc4(pc4), .npc_op(npc_op), .rs_data(rs_data), .stall(stall),
    .halt(halt), .retired(retired)
  );
  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function logic [31:0] word(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction
  function logic [31:0] target(input logic [31:0] p, input logic [31:0] w, input logic [2:0] op, input logic [31:0] rs);
    logic [31:0] lp;
    lp = p + 32'd4;
    case (op)
      3'd1:    return lp + 32'($signed(w[15:0])) * 32'd4;
      3'd2:    return {lp[31:28], w[25:0], 2'b00};
      3'd3:    return rs;
      default: return lp;
    endcase
  endfunction
  task run(input int dly, input int stalls, input logic [2:0] op, input logic [31:0] rs);
    logic [31:0] w, t, old;
    w = word(m_pc);
    chk("fetch_req", imem.req, 1);
    chk("fetch_addr", imem.addr, m_pc);
    chk("fetch_valid", instr_valid, 0);
    repeat (dly) begin
      imem.ack = 0;
      imem.rdata = $urandom;
      @(posedge clk); @(negedge clk);
      chk("wait_req", imem.req, 1);
      chk("wait_addr", imem.addr, m_pc);
      chk("wait_valid", instr_valid, 0);
    end
    imem.ack = 1;
    imem.rdata = w;
    @(posedge clk); @(negedge clk);
    imem.ack = 0;
    imem.rdata = $urandom;
    chk("exec_instr", instr, w);
    chk("exec_valid", instr_valid, 1);
    chk("exec_pc", pc, m_pc);
    chk("exec_pc4", pc4, m_pc + 32'd4);
    chk("exec_req", imem.req, 0);
    chk("exec_retired", retired, m_ret);
    repeat (stalls) begin
      stall = 1;
      imem.ack = 1;
      imem.rdata = $urandom;
      @(posedge clk); @(negedge clk);
      chk("stall_instr", instr, w);
      chk("stall_pc", pc, m_pc);
      chk("stall_retired", retired, m_ret);
      chk("stall_valid", instr_valid, 1);
    end
    stall = 0;
    imem.ack = 0;
    npc_op = op;
    rs_data = rs;
    @(posedge clk); @(negedge clk);
    old = m_pc;
    t = target(m_pc, w, op, rs);
`ifdef ALIGN_CHECK_EN
    if (t[1:0] != 2'b00) m_halt = 1;
    else begin
      m_pc = t;
      m_ret++;
    end
`else
    m_pc = t & ~32'd3;
    m_ret++;
`endif
    chk("halt", halt, m_halt);
    chk("retired", retired, m_ret);
    if (m_halt) begin
      chk("halt_req", imem.req, 0);
      chk("halt_valid", instr_valid, 0);
      chk("halt_pc", pc, old);
    end
  endtask
  initial begin
    imem.ack = 0;
    imem.rdata = 0;
    stall = 0;
    npc_op = 0;
    rs_data = 0;
    m_pc = 32'h3000;
    m_ret = 0;
    m_halt = 0;
    repeat (2) @(negedge clk);
    chk("rst_req", imem.req, 0);
    chk("rst_pc", pc, 32'h3000);
    chk("rst_halt", halt, 0);
    rst_n = 1;
    #1;
    repeat (3) run(0, 0, 3'd0, 32'h0);
    chk("t2_addr", imem.addr, 32'h300C);
    chk("t2_retired", retired, 3);
    imem.ack = 1;
    imem.rdata = 32'hDEAD_BEEF;
    @(posedge clk); @(negedge clk);
    imem.ack = 0;
    chk("t1_pre_valid", instr_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("t1_pc", pc, 32'h3000);
    chk("t1_valid", instr_valid, 0);
    chk("t1_retired", retired, 0);
    chk("t1_instr", instr, 0);
    chk("t1_req", imem.req, 0);
    @(negedge clk);
    rst_n = 1;
    m_pc = 32'h3000;
    m_ret = 0;
    #1;
    mem[32'h3004] = 32'h1000_FFFE;
    run(0, 0, 3'd0, 32'h0);
    run(0, 0, 3'd1, 32'h0);
    chk("t3_addr", imem.addr, 32'h3000);
    mem[32'h3000] = {6'h02, 26'h000_0C10};
    run(0, 0, 3'd2, 32'h0);
    chk("t4_j_addr", imem.addr, 32'h3040);
    run(0, 0, 3'd3, 32'h3100);
    chk("t4_jr_addr", imem.addr, 32'h3100);
    run(3, 2, 3'd0, 32'h0);
    chk("t5_addr", imem.addr, 32'h3104);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] rs;
      rs = $urandom;
`ifdef ALIGN_CHECK_EN
      rs[1:0] = 2'b00;
`endif
      run($urandom_range(0, 3), $urandom_range(0, 2), 3'($urandom_range(0, 7)), rs);
    end
    run(0, 0, 3'd3, 32'h3100);
    run(0, 0, 3'd3, 32'h3102);
`ifdef ALIGN_CHECK_EN
    repeat (3) begin
      imem.ack = 1;
      @(posedge clk); @(negedge clk);
      chk("t6_halt", halt, 1);
      chk("t6_req", imem.req, 0);
      chk("t6_pc", pc, 32'h3100);
    end
`else
    chk("t6_addr", imem.addr, 32'h3100);
    chk("t6_halt", halt, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
